// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
//   Shared types and constants for the MIPS pipeline control blocks.
//   hz_state_t     : hazard sequencer states (RUN, MEM_WAIT, HALT)
//   DEF_REG_ADDR_W : default register-specifier width
package mips_pipe_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

endpackage : mips_pipe_pkg

// File: rtl/load_use_detect.sv
// load_use_detect
//   Combinational load-use hazard comparator. Flags when the load in EX
//   writes a register that the instruction in ID reads. Register 0 is never
//   a hazard because it is hard-wired to zero.
// Ports:
//   memread   in  load in EX
//   load_rt   in  load destination register
//   id_rs     in  rs of instruction in ID
//   id_rt     in  rt of instruction in ID
//   id_uses_rt in ID instruction reads rt
//   load_use  out hazard condition
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  memread,
  input  logic [REG_ADDR_W-1:0] load_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (load_rt == id_rs);
  assign rt_match = id_uses_rt && (load_rt == id_rt);
  assign load_use = memread && (load_rt != '0) && (rs_match || rt_match);

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage MIPS pipeline. Handles load-use
//   bubbles, taken-branch squash, and data-memory wait freezes with a
//   timeout watchdog that halts the core.
//   Optional build macro HAZARD_PERF_CNT_EN enables the saturating perf
//   counters; without it stall_cycles/flush_count are tied to zero.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   IDEX_memread_ctrl, IDEX_reg_rt     load in EX and its destination
//   IFID_reg_rs, IFID_reg_rt, IFID_uses_rt  ID-stage source registers
//   branch_taken                branch in EX resolved taken
//   dmem_req, dmem_ready        data-memory handshake
//   pc_write_en .. MEMWB_bubble pipeline register controls (Mealy)
//   halted                      sticky memory-timeout halt
//   stall_cycles, flush_count   perf counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; load-use / branch hazards resolved here
// MEM_WAIT | pipeline frozen awaiting dmem_ready; wait_cnt counts cycles
// HALT     | memory timeout; everything frozen until reset
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IDEX_memread_ctrl,
  input  logic [REG_ADDR_W-1:0] IDEX_reg_rt,
  input  logic [REG_ADDR_W-1:0] IFID_reg_rs,
  input  logic [REG_ADDR_W-1:0] IFID_reg_rt,
  input  logic                  IFID_uses_rt,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write_en,
  output logic                  IFID_write_en,
  output logic                  IFID_flush,
  output logic                  IDEX_write_en,
  output logic                  IDEX_bubble,
  output logic                  EXMEM_write_en,
  output logic                  MEMWB_bubble,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;

  hz_state_t         state;
  hz_state_t         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              load_use;
  logic              freeze;
  logic              hazard_eval;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .memread    (IDEX_memread_ctrl),
    .load_rt    (IDEX_reg_rt),
    .id_rs      (IFID_reg_rs),
    .id_rt      (IFID_reg_rt),
    .id_uses_rt (IFID_uses_rt),
    .load_use   (load_use)
  );

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    freeze         = 1'b0;
    hazard_eval    = 1'b0;
    pc_write_en    = 1'b1;
    IFID_write_en  = 1'b1;
    IFID_flush     = 1'b0;
    IDEX_write_en  = 1'b1;
    IDEX_bubble    = 1'b0;
    EXMEM_write_en = 1'b1;
    MEMWB_bubble   = 1'b0;

    case (state)
      RUN: begin
        // Same-cycle ready is a zero-wait access and never freezes.
        if (dmem_req && !dmem_ready) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end else begin
          hazard_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            state_nxt = HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          // Release cycle: hazards held frozen in EX/ID resolve now.
          hazard_eval  = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      HALT: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (freeze) begin
      pc_write_en    = 1'b0;
      IFID_write_en  = 1'b0;
      IDEX_write_en  = 1'b0;
      EXMEM_write_en = 1'b0;
      MEMWB_bubble   = 1'b1;
    end

    // Branch squashes the ID instruction, so it outranks load-use.
    if (hazard_eval) begin
      if (branch_taken) begin
        IFID_flush  = 1'b1;
        IDEX_bubble = 1'b1;
      end else if (load_use) begin
        pc_write_en   = 1'b0;
        IFID_write_en = 1'b0;
        IDEX_bubble   = 1'b1;
      end
    end

    // Outputs follow reset immediately, not at the next edge.
    if (!rst_n) begin
      pc_write_en    = 1'b0;
      IFID_write_en  = 1'b0;
      IFID_flush     = 1'b0;
      IDEX_write_en  = 1'b0;
      IDEX_bubble    = 1'b0;
      EXMEM_write_en = 1'b0;
      MEMWB_bubble   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign halted = (state == HALT);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (IFID_flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed scenarios plus randomized traffic checked against a
//   cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int RW       = 5;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          IDEX_memread_ctrl;
  logic [RW-1:0] IDEX_reg_rt;
  logic [RW-1:0] IFID_reg_rs;
  logic [RW-1:0] IFID_reg_rt;
  logic          IFID_uses_rt;
  logic          branch_taken;
  logic          dmem_req;
  logic          dmem_ready;
  logic          pc_write_en;
  logic          IFID_write_en;
  logic          IFID_flush;
  logic          IDEX_write_en;
  logic          IDEX_bubble;
  logic          EXMEM_write_en;
  logic          MEMWB_bubble;
  logic          halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (RW),
    .MAX_WAIT   (MAX_WAIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .IDEX_memread_ctrl (IDEX_memread_ctrl),
    .IDEX_reg_rt       (IDEX_reg_rt),
    .IFID_reg_rs       (IFID_reg_rs),
    .IFID_reg_rt       (IFID_reg_rt),
    .IFID_uses_rt      (IFID_uses_rt),
    .branch_taken      (branch_taken),
    .dmem_req          (dmem_req),
    .dmem_ready        (dmem_ready),
    .pc_write_en       (pc_write_en),
    .IFID_write_en     (IFID_write_en),
    .IFID_flush        (IFID_flush),
    .IDEX_write_en     (IDEX_write_en),
    .IDEX_bubble       (IDEX_bubble),
    .EXMEM_write_en    (EXMEM_write_en),
    .MEMWB_bubble      (MEMWB_bubble),
    .halted            (halted),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: consecutive unresolved memory cycles, halt flag, counts.
  int          m_wait  = 0;
  bit          m_halt  = 1'b0;
  longint      m_stall = 0;
  longint      m_flush = 0;
  logic [7:0]  exp_out;
  bit          exp_freeze;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] out_vec();
    return {pc_write_en, IFID_write_en, IFID_flush, IDEX_write_en,
            IDEX_bubble, EXMEM_write_en, MEMWB_bubble, halted};
  endfunction

  function automatic longint cnt_exp(input longint v);
`ifdef HAZARD_PERF_CNT_EN
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
`else
    return (v == 0) ? 0 : 0;
`endif
  endfunction

  // Expected output vector order: pc, ifid_we, ifid_flush, idex_we,
  // idex_bubble, exmem_we, memwb_bubble, halted.
  task automatic model_eval();
    bit lu;
    lu = IDEX_memread_ctrl && (IDEX_reg_rt != 0) &&
         ((IDEX_reg_rt == IFID_reg_rs) || (IFID_uses_rt && (IDEX_reg_rt == IFID_reg_rt)));
    exp_freeze = (m_wait == 0) ? (dmem_req && !dmem_ready) : !dmem_ready;
    if (m_halt)            exp_out = 8'b0000_0011;
    else if (exp_freeze)   exp_out = 8'b0000_0010;
    else if (branch_taken) exp_out = 8'b1111_1100;
    else if (lu)           exp_out = 8'b0001_1100;
    else                   exp_out = 8'b1101_0100;
  endtask

  task automatic model_reset();
    m_wait = 0; m_halt = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic drive(input bit mr, input int ld, input int rs, input int rt,
                       input bit ur, input bit br, input bit rq, input bit rdy);
    IDEX_memread_ctrl = mr;
    IDEX_reg_rt       = RW'(ld);
    IFID_reg_rs       = RW'(rs);
    IFID_reg_rt       = RW'(rt);
    IFID_uses_rt      = ur;
    branch_taken      = br;
    dmem_req          = rq;
    dmem_ready        = rdy;
  endtask

  // Called with clk low just after a falling edge; checks, advances model,
  // lets one rising edge pass and returns at the next falling edge.
  task automatic tick(input string tag);
    #1;
    model_eval();
    check({tag, "_out"},   64'(out_vec()),     64'(exp_out));
    check({tag, "_stall"}, 64'(stall_cycles), 64'(cnt_exp(m_stall)));
    check({tag, "_flush"}, 64'(flush_count),  64'(cnt_exp(m_flush)));
    if (!exp_out[7]) m_stall++;
    if (exp_out[5])  m_flush++;
    if (!m_halt) begin
      if (exp_freeze) begin
        m_wait++;
        if (m_wait == MAX_WAIT) m_halt = 1'b1;
      end else begin
        m_wait = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out"},   64'(out_vec()),    64'(0));
    check({tag, "_stall"}, 64'(stall_cycles), 64'(0));
    check({tag, "_flush"}, 64'(flush_count),  64'(0));
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int halt_run;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 8, 8, 0, 0, 1, 1, 0);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick("idle");

    // Load-use variants
    drive(1, 8, 8, 0, 0, 0, 0, 0); tick("lu_rs");
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("lu_after");
    drive(1, 0, 0, 0, 1, 0, 0, 0); tick("lu_r0");
    drive(1, 8, 3, 8, 0, 0, 0, 0); tick("lu_nouse");
    drive(1, 8, 3, 8, 1, 0, 0, 0); tick("lu_rt");

    // Branch beats load-use
    drive(1, 8, 8, 0, 0, 1, 0, 0); tick("br_lu");
    drive(0, 0, 0, 0, 0, 0, 1, 1); tick("zero_wait");

    // Three-cycle memory wait then release
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 1, 0); tick("mw_frz"); end
    drive(0, 0, 0, 0, 0, 0, 1, 1); tick("mw_rel");
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("mw_post");

    // Branch held frozen through a 2-cycle wait flushes on release
    repeat (2) begin drive(0, 0, 0, 0, 0, 1, 1, 0); tick("fb_frz"); end
    drive(0, 0, 0, 0, 0, 1, 1, 1); tick("fb_rel");
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("fb_post");

    // Timeout into HALT, sticky against dmem_ready
    repeat (MAX_WAIT) begin drive(0, 0, 0, 0, 0, 0, 1, 0); tick("to_frz"); end
    repeat (3) begin drive(0, 0, 0, 0, 0, 1, 1, 1); tick("to_halt"); end
    reset_pulse("to_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("to_clear");

    // Ready on the last allowed cycle releases instead of halting
    repeat (MAX_WAIT - 1) begin drive(0, 0, 0, 0, 0, 0, 1, 0); tick("rl_frz"); end
    drive(0, 0, 0, 0, 0, 0, 1, 1); tick("rl_rel");
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("rl_post");

    // Asynchronous reset in the middle of a wait
    repeat (2) begin drive(0, 0, 0, 0, 0, 0, 1, 0); tick("ar_frz"); end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("ar_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick("ar_post");

    // Randomized traffic
    halt_run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halt) halt_run++;
      else halt_run = 0;
      if (halt_run > 4 || $urandom_range(0, 299) == 0) begin
        halt_run = 0;
        reset_pulse("rnd_rst");
      end
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1), ($urandom_range(0, 4) < 2));
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
